// File: rtl/dw01_pkg.sv
// Shared definitions for the dw01 pipelined adder macros: operand width,
// half width and the stage-1 payload carried across the split carry chain.
package dw01_pkg;

    localparam int unsigned DW01_ADD_WIDTH = 8;
    localparam int unsigned DW01_ADD_HALF  = DW01_ADD_WIDTH / 2;

    // Low-half partial sum, its carry, and the untouched high halves of A and B.
    typedef struct packed {
        logic [DW01_ADD_HALF-1:0] lo;
        logic                     c;
        logic [DW01_ADD_HALF-1:0] ahi;
        logic [DW01_ADD_HALF-1:0] bhi;
    } dw01_s1_t;

endpackage

// File: rtl/dw01_add_slice.sv
// Purely combinational W-bit adder with carry-in and carry-out.
// Used once per pipeline stage to add one half of the operands.
module dw01_add_slice
    import dw01_pkg::*;
#(
    parameter int unsigned W = DW01_ADD_HALF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    logic [W:0] total;

    // Zero-extend every term to W+1 bits so the top bit is the carry-out.
    always_comb begin
        total = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
        s_o   = total[W-1:0];
        co_o  = total[W];
    end

endmodule

// File: rtl/dw01_add_pipe_8.sv
// Two-stage pipelined adder: SUM = A + B + CI with carry-out, valid/ready
// handshake on both sides. The low half is added in stage 1, the high half in
// stage 2, so the carry chain is cut by a register.
// Optional feature macro: DW01_ADD_OVF_EN adds the registered signed-overflow
// output ovf; without it the port and its flop are absent.
// WIDTH must match DW01_ADD_WIDTH because the stage-1 payload struct is sized
// from the package.
module dw01_add_pipe_8
    import dw01_pkg::*;
#(
    parameter int unsigned WIDTH = DW01_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef DW01_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);

    localparam int unsigned HALF = WIDTH / 2;

    // Stage 1 state
    logic     s1_valid_q, s1_valid_d;
    dw01_s1_t s1_q, s1_d;

    // Stage 2 state (drives the outputs directly)
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
`ifdef DW01_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic            s2_ready;
    logic [HALF-1:0] lo_s, hi_s;
    logic            lo_c, hi_c;

    // Low-half adder feeding stage 1.
    dw01_add_slice #(
        .W (HALF)
    ) u_slice_lo (
        .a_i  (a[HALF-1:0]),
        .b_i  (b[HALF-1:0]),
        .ci_i (ci),
        .s_o  (lo_s),
        .co_o (lo_c)
    );

    // High-half adder feeding stage 2, consuming the registered low carry.
    dw01_add_slice #(
        .W (HALF)
    ) u_slice_hi (
        .a_i  (s1_q.ahi),
        .b_i  (s1_q.bhi),
        .ci_i (s1_q.c),
        .s_o  (hi_s),
        .co_o (hi_c)
    );

    // Ready chain: a stage can load when it is empty or the stage after it
    // is draining this cycle, so a full pipe still streams without a bubble.
    always_comb begin
        s2_ready = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
    end

    // Stage 1 next state: data only moves for a real beat, so idle cycles
    // leave the payload registers untouched.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.lo  = lo_s;
                s1_d.c   = lo_c;
                s1_d.ahi = a[WIDTH-1:HALF];
                s1_d.bhi = b[WIDTH-1:HALF];
            end
        end
    end

    // Stage 2 next state: completes the high half and holds while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        co_d       = co_q;
`ifdef DW01_ADD_OVF_EN
        ovf_d      = ovf_q;
`endif
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d = {hi_s, s1_q.lo};
                co_d  = hi_c;
`ifdef DW01_ADD_OVF_EN
                // Overflow: operands agree in sign but the result does not.
                ovf_d = (s1_q.ahi[HALF-1] == s1_q.bhi[HALF-1]) &&
                        (hi_s[HALF-1] != s1_q.ahi[HALF-1]);
`endif
            end
        end
    end

    // Pipeline registers; reset clears every valid and data flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            co_q       <= 1'b0;
`ifdef DW01_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            co_q       <= co_d;
`ifdef DW01_ADD_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Output drive straight from stage 2.
    always_comb begin
        out_valid = s2_valid_q;
        sum       = sum_q;
        co        = co_q;
`ifdef DW01_ADD_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_dw01_add_pipe_8.sv
// Self-checking bench for dw01_add_pipe_8. Inputs change 1 ns after the rising
// edge; outputs and handshake signals are sampled on the falling edge.
module tb_dw01_add_pipe_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       co;
    logic       ovf_obs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dw01_add_pipe_8 #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef DW01_ADD_OVF_EN
        .ovf       (ovf_obs),
`endif
        .co        (co)
    );

`ifndef DW01_ADD_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    // Reference: {ovf, co, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic c);
        int unsigned u;
        int          sx, sy, r;
        logic        v;
        u  = int'(x) + int'(y) + int'(c);
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        r  = sx + sy + int'(c);
        v  = (r > 127) || (r < -128);
`ifndef DW01_ADD_OVF_EN
        v  = 1'b0;
`endif
        return {v, u[8], u[7:0]};
    endfunction

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic ordy);
        in_valid  = v;
        a         = x;
        b         = y;
        ci        = c;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 ||
                co !== 1'b0 || ovf_obs !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got rdy=%b ov=%b sum=%h co=%b ovf=%b want 1 0 00 0 0",
                         i, in_ready, out_valid, sum, co, ovf_obs);
            end
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        drive(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_accept got in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== 8'h4B || co !== 1'b0) begin
            failures++;
            $display("FAIL single_result got v=%b sum=%h co=%b want 1 4b 0", out_valid, sum, co);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_retire got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xa [3];
        logic [7:0] xb [3];
        logic [7:0] es [3];
        logic       ec [3];
        logic       ev [3];
        xa = '{8'hFF, 8'h80, 8'h7F};
        xb = '{8'h01, 8'h80, 8'h01};
        es = '{8'h00, 8'h00, 8'h80};
        ec = '{1'b1, 1'b1, 1'b0};
`ifdef DW01_ADD_OVF_EN
        ev = '{1'b0, 1'b1, 1'b1};
`else
        ev = '{1'b0, 1'b0, 1'b0};
`endif
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 3) drive(1'b1, xa[c], xb[c], 1'b0, 1'b1);
            else       drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== es[c-2] || co !== ec[c-2] ||
                    ovf_obs !== ev[c-2]) begin
                    failures++;
                    $display("FAIL stream_res%0d got v=%b sum=%h co=%b ovf=%b want 1 %h %b %b",
                             c-2, out_valid, sum, co, ovf_obs, es[c-2], ec[c-2], ev[c-2]);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_idle%0d got out_valid=%b want 0", c, out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] r0, r1, r2;
        logic [7:0] hold_sum;
        r0 = ref_add(8'h10, 8'h20, 1'b0);
        r1 = ref_add(8'hF0, 8'h20, 1'b1);
        r2 = ref_add(8'h55, 8'hAA, 1'b1);
        // Two beats fill the pipe with the output stalled.
        @(posedge clk); #1; drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_accept0 got in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1; drive(1'b1, 8'hF0, 8'h20, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_accept1 got in_ready=%b want 1", in_ready);
        end
        // Third beat offered and held: pipe is full, must be refused.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1; drive(1'b1, 8'h55, 8'hAA, 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== r0[7:0] || co !== r0[8]) begin
                failures++;
                $display("FAIL bp_full%0d got rdy=%b v=%b sum=%h co=%b want 0 1 %h %b",
                         i, in_ready, out_valid, sum, co, r0[7:0], r0[8]);
            end
        end
        hold_sum = sum;
        // Release: in_ready returns in the same cycle.
        @(posedge clk); #1; drive(1'b1, 8'h55, 8'hAA, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || sum !== hold_sum) begin
            failures++;
            $display("FAIL bp_release got rdy=%b v=%b sum=%h want 1 1 %h", in_ready, out_valid, sum, hold_sum);
        end
        @(posedge clk); #1; drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== r1[7:0] || co !== r1[8]) begin
            failures++;
            $display("FAIL bp_res1 got v=%b sum=%h co=%b want 1 %h %b", out_valid, sum, co, r1[7:0], r1[8]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== r2[7:0] || co !== r2[8]) begin
            failures++;
            $display("FAIL bp_res2 got v=%b sum=%h co=%b want 1 %h %b", out_valid, sum, co, r2[7:0], r2[8]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drained got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [9:0] exp_r;
        logic       held;
        logic       stalled;
        logic [9:0] prev_out;
        int         sent;
        int         cyc;
        held    = 1'b0;
        stalled = 1'b0;
        prev_out = '0;
        sent    = 0;
        cyc     = 0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            @(posedge clk); #1;
            if (!held) begin
                if (sent < 10000)
                    drive(($urandom_range(3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                else
                    in_valid = 1'b0;
            end
            out_ready = (sent >= 10000) ? 1'b1 : ($urandom_range(3) != 0);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {ovf_obs, co, sum} !== prev_out) begin
                    failures++;
                    $display("FAIL rand_stall cyc=%0d got v=%b out=%h want 1 %h",
                             cyc, out_valid, {ovf_obs, co, sum}, prev_out);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra cyc=%0d got out=%h want no result", cyc, {ovf_obs, co, sum});
                end else begin
                    exp_r = q[0];
                    if ({ovf_obs, co, sum} !== exp_r) begin
                        failures++;
                        $display("FAIL rand_data cyc=%0d got out=%h want %h", cyc, {ovf_obs, co, sum}, exp_r);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            stalled  = (out_valid === 1'b1) && !out_ready;
            prev_out = {ovf_obs, co, sum};
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, ci));
                sent++;
            end
            held = in_valid && !in_ready;
            cyc++;
        end
        checks++;
        if (sent != 10000 || q.size() != 0) begin
            failures++;
            $display("FAIL rand_budget got sent=%0d pending=%0d want 10000 0", sent, q.size());
        end
        @(posedge clk); #1; drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1; drive(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_full got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || co !== 1'b0 || ovf_obs !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_clear got v=%b sum=%h co=%b ovf=%b rdy=%b want 0 00 0 0 1",
                     out_valid, sum, co, ovf_obs, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; drive(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
        @(posedge clk); #1; drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_stale got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || sum !== 8'h03 || co !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after got v=%b sum=%h co=%b want 1 03 0", out_valid, sum, co);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
